// File: rtl/hex_display_ctrl.sv
// rtl/hex_display_ctrl.sv - shares one hex-to-7-segment decoder across NUM_DIGITS displays
// Optional blink stage enabled by macro HEX_BLINK_EN.
module hex_display_ctrl #(
    parameter int NUM_DIGITS = 8
`ifdef HEX_BLINK_EN
    ,
    parameter int BLINK_DIV  = 25_000_000
`endif
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_valid,
    output logic                    o_ready,
    input  logic [4*NUM_DIGITS-1:0] i_data,
    input  logic                    i_blank_en,
`ifdef HEX_BLINK_EN
    input  logic [NUM_DIGITS-1:0]   i_blink_mask,
`endif
    output logic [7*NUM_DIGITS-1:0] o_hex,
    output logic                    o_done
);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam logic [6:0] SEG_OFF = 7'h7F;

    typedef enum logic {IDLE, SCAN} state_e;

    state_e                  state_q;
    logic [4*NUM_DIGITS-1:0] data_q;
    logic                    blank_en_q;
    logic [IW-1:0]           idx_q;
    logic                    nz_q;
    logic                    ready_q;
    logic                    done_q;
    logic [7*NUM_DIGITS-1:0] hex_q;

    logic [3:0] nibble;
    logic [6:0] seg;
    logic       blank;

    always_comb begin
        nibble = 4'h0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx_q == IW'(k)) nibble = data_q[4*k +: 4];
        end
    end

    // The single shared decoder, active-low gfedcba.
    always_comb begin
        seg = SEG_OFF;
        case (nibble)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            4'hF: seg = 7'h0E;
            default: seg = SEG_OFF;
        endcase
    end

    assign blank = blank_en_q && !nz_q && (nibble == 4'h0) && (idx_q != '0);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q    <= IDLE;
            data_q     <= '0;
            blank_en_q <= 1'b0;
            idx_q      <= '0;
            nz_q       <= 1'b0;
            ready_q    <= 1'b1;
            done_q     <= 1'b0;
            hex_q      <= {NUM_DIGITS{SEG_OFF}};
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (i_valid) begin
                        data_q     <= i_data;
                        blank_en_q <= i_blank_en;
                        idx_q      <= IW'(NUM_DIGITS - 1);
                        nz_q       <= 1'b0;
                        ready_q    <= 1'b0;
                        state_q    <= SCAN;
                    end
                end
                SCAN: begin
                    for (int k = 0; k < NUM_DIGITS; k++) begin
                        if (idx_q == IW'(k)) hex_q[7*k +: 7] <= blank ? SEG_OFF : seg;
                    end
                    nz_q <= nz_q | (nibble != 4'h0);
                    if (idx_q == '0) begin
                        state_q <= IDLE;
                        ready_q <= 1'b1;
                        done_q  <= 1'b1;
                    end else begin
                        idx_q <= idx_q - 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_ready = ready_q;
    assign o_done  = done_q;

`ifdef HEX_BLINK_EN
    localparam int CW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [CW-1:0]           cnt_q;
    logic                    phase_q;
    logic [7*NUM_DIGITS-1:0] out_q;
    logic [7*NUM_DIGITS-1:0] masked;

    always_comb begin
        masked = hex_q;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (phase_q && i_blink_mask[k]) masked[7*k +: 7] = SEG_OFF;
        end
    end

    // Mask is applied in a register so the pins see no path from i_blink_mask.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
            out_q   <= {NUM_DIGITS{SEG_OFF}};
        end else begin
            if (cnt_q == CW'(BLINK_DIV - 1)) begin
                cnt_q   <= '0;
                phase_q <= ~phase_q;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
            out_q <= masked;
        end
    end

    assign o_hex = out_q;
`else
    assign o_hex = hex_q;
`endif

endmodule

// File: tb/tb_hex_display_ctrl.sv
// tb/tb_hex_display_ctrl.sv - randomized self-checking bench for hex_display_ctrl
module tb_hex_display_ctrl;
    localparam int N = 8;
    localparam logic [6:0] OFF = 7'h7F;

    logic            i_clk = 1'b0;
    logic            i_reset = 1'b1;
    logic            i_valid = 1'b0;
    logic            o_ready;
    logic [4*N-1:0]  i_data = '0;
    logic            i_blank_en = 1'b0;
    logic [7*N-1:0]  o_hex;
    logic            o_done;
`ifdef HEX_BLINK_EN
    logic [N-1:0]    i_blink_mask = '0;
`endif

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    logic [7*N-1:0] cur;
    logic [7*N-1:0] prev;

    always #5 i_clk = ~i_clk;

`ifdef HEX_BLINK_EN
    hex_display_ctrl #(.NUM_DIGITS(N), .BLINK_DIV(4)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_valid(i_valid), .o_ready(o_ready),
        .i_data(i_data), .i_blank_en(i_blank_en), .i_blink_mask(i_blink_mask),
        .o_hex(o_hex), .o_done(o_done));
`else
    hex_display_ctrl #(.NUM_DIGITS(N)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_valid(i_valid), .o_ready(o_ready),
        .i_data(i_data), .i_blank_en(i_blank_en),
        .o_hex(o_hex), .o_done(o_done));
`endif

    // Final display: leading zeros above the most significant nonzero digit are blank, digit 0 never.
    function automatic logic [7*N-1:0] model(input logic [4*N-1:0] w, input logic b);
        logic [7*N-1:0] r;
        int lead;
        lead = -1;
        for (int k = 0; k < N; k++) if (w[4*k +: 4] != 4'h0) lead = k;
        for (int k = 0; k < N; k++) begin
            if (b && k > lead && k != 0) r[7*k +: 7] = OFF;
            else                         r[7*k +: 7] = seg_tab[w[4*k +: 4]];
        end
        return r;
    endfunction

    task automatic test_reset();
        i_reset = 1'b1;
        repeat (2) @(posedge i_clk);
        #1;
        total_cnt++;
        if (o_hex !== {N{OFF}}) $display("FAIL reset_hex actual=%h required=%h", o_hex, {N{OFF}});
        else pass_cnt++;
        total_cnt++;
        if (o_ready !== 1'b1) $display("FAIL reset_ready actual=%b required=1", o_ready);
        else pass_cnt++;
        total_cnt++;
        if (o_done !== 1'b0) $display("FAIL reset_done actual=%b required=0", o_done);
        else pass_cnt++;
        i_reset = 1'b0;
        cur  = {N{OFF}};
        prev = {N{OFF}};
    endtask

    task automatic test_load(input logic [4*N-1:0] w, input logic b);
        logic [7*N-1:0] full;
        logic [7*N-1:0] shown;
        full = model(w, b);
        i_data = w; i_blank_en = b; i_valid = 1'b1;
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        total_cnt++;
        if (o_ready !== 1'b0) $display("FAIL load_ready_after_accept w=%h actual=%b required=0", w, o_ready);
        else pass_cnt++;
        for (int j = 0; j < N; j++) begin
            @(posedge i_clk); #1;
            cur[7*(N-1-j) +: 7] = full[7*(N-1-j) +: 7];
`ifdef HEX_BLINK_EN
            shown = prev;
`else
            shown = cur;
`endif
            prev = cur;
            total_cnt++;
            if (o_hex !== shown) $display("FAIL load_progress w=%h step=%0d actual=%h required=%h", w, j, o_hex, shown);
            else pass_cnt++;
            total_cnt++;
            if (o_done !== (j == N-1)) $display("FAIL load_done w=%h step=%0d actual=%b required=%b", w, j, o_done, j == N-1);
            else pass_cnt++;
            total_cnt++;
            if (o_ready !== (j == N-1)) $display("FAIL load_ready w=%h step=%0d actual=%b required=%b", w, j, o_ready, j == N-1);
            else pass_cnt++;
        end
        @(posedge i_clk); #1;
        total_cnt++;
        if (o_done !== 1'b0) $display("FAIL load_done_single w=%h actual=%b required=0", w, o_done);
        else pass_cnt++;
        total_cnt++;
        if (o_hex !== full) $display("FAIL load_final w=%h actual=%h required=%h", w, o_hex, full);
        else pass_cnt++;
    endtask

    task automatic test_random();
        logic [4*N-1:0] w;
        for (int i = 0; i < 12; i++) begin
            w = $urandom;
            w = w >> (4 * $urandom_range(0, N));
            test_load(w, 1'($urandom_range(0, 1)));
        end
    endtask

    task automatic test_back_to_back();
        int cyc, pulses, first;
        i_data = 32'h1111_1111; i_blank_en = 1'b0; i_valid = 1'b1;
        @(posedge i_clk); #1;
        i_data = 32'hFFFF_FFFF;
        cyc = 0; pulses = 0; first = 0;
        while (pulses < 2 && cyc < 40) begin
            @(posedge i_clk); #1;
            cyc++;
            if (o_done === 1'b1) begin
                pulses++;
                if (pulses == 1) begin
                    first = cyc;
                    total_cnt++;
                    if (o_hex[7*N-1:7] !== {(N-1){7'h79}})
                        $display("FAIL b2b_first_word actual=%h required=%h", o_hex[7*N-1:7], {(N-1){7'h79}});
                    else pass_cnt++;
                end else begin
                    i_valid = 1'b0;
                    total_cnt++;
                    if (cyc - first !== 9) $display("FAIL b2b_spacing actual=%0d required=9", cyc - first);
                    else pass_cnt++;
                end
            end else if (cyc > 0) begin
                total_cnt++;
                if (o_ready !== 1'b0) $display("FAIL b2b_ready_busy cyc=%0d actual=%b required=0", cyc, o_ready);
                else pass_cnt++;
            end
        end
        i_valid = 1'b0;
        total_cnt++;
        if (pulses !== 2) $display("FAIL b2b_pulses actual=%0d required=2", pulses);
        else pass_cnt++;
        @(posedge i_clk); #1;
        total_cnt++;
        if (o_hex !== {N{7'h0E}}) $display("FAIL b2b_final actual=%h required=%h", o_hex, {N{7'h0E}});
        else pass_cnt++;
        cur = {N{7'h0E}}; prev = cur;
    endtask

    task automatic test_reset_mid_scan();
        int dones;
        i_data = 32'h8888_8888; i_blank_en = 1'b0; i_valid = 1'b1;
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        repeat (2) @(posedge i_clk);
        #1;
        i_reset = 1'b1;
        @(posedge i_clk); #1;
        i_reset = 1'b0;
        total_cnt++;
        if (o_hex !== {N{OFF}}) $display("FAIL midrst_hex actual=%h required=%h", o_hex, {N{OFF}});
        else pass_cnt++;
        total_cnt++;
        if (o_ready !== 1'b1) $display("FAIL midrst_ready actual=%b required=1", o_ready);
        else pass_cnt++;
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            if (o_done === 1'b1) dones++;
            @(posedge i_clk); #1;
        end
        total_cnt++;
        if (dones !== 0) $display("FAIL midrst_no_done actual=%0d required=0", dones);
        else pass_cnt++;
        total_cnt++;
        if (o_hex !== {N{OFF}}) $display("FAIL midrst_hex_after actual=%h required=%h", o_hex, {N{OFF}});
        else pass_cnt++;
        cur = {N{OFF}}; prev = cur;
    endtask

`ifdef HEX_BLINK_EN
    task automatic test_blink();
        logic [6:0] last;
        int run, runs_ok;
        test_load(32'h0000_0005, 1'b0);
        i_blink_mask = 8'h01;
        repeat (2) @(posedge i_clk);
        #1;
        last = o_hex[6:0]; run = 0; runs_ok = 0;
        for (int i = 0; i < 24; i++) begin
            @(posedge i_clk); #1;
            total_cnt++;
            if (o_hex[7*N-1:7] !== {(N-1){7'h40}}) $display("FAIL blink_steady actual=%h", o_hex[7*N-1:7]);
            else pass_cnt++;
            total_cnt++;
            if (o_hex[6:0] !== 7'h12 && o_hex[6:0] !== OFF) $display("FAIL blink_value actual=%h required=12_or_7f", o_hex[6:0]);
            else pass_cnt++;
            run++;
            if (o_hex[6:0] !== last) begin
                if (runs_ok > 0 || run == 4) begin
                    total_cnt++;
                    if (run !== 4 && runs_ok > 0) $display("FAIL blink_period actual=%0d required=4", run);
                    else pass_cnt++;
                end
                runs_ok++;
                run = 0;
                last = o_hex[6:0];
            end
        end
        total_cnt++;
        if (runs_ok < 5) $display("FAIL blink_toggles actual=%0d required=5", runs_ok);
        else pass_cnt++;
        i_blink_mask = '0;
    endtask
`endif

    initial begin
        @(posedge i_clk); #1;
        test_reset();
        test_load(32'h0123_4567, 1'b0);
        test_load(32'h0000_00A0, 1'b1);
        test_load(32'h0000_0000, 1'b1);
        test_load(32'h0000_0000, 1'b0);
        test_random();
        test_back_to_back();
        test_reset_mid_scan();
`ifdef HEX_BLINK_EN
        test_blink();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
